pipe_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RISC-V pipeline. It collects every hazard source: load-use hold from the forwarding unit, data-bus wait, multi-cycle divider, fetch wait, EX-stage jump and the external interrupt. It resolves them by fixed priority into per-stage hold/flush controls and the PC redirect. It also owns interrupt entry/exit sequencing (EPC capture) and a data-bus stall watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/pipe_ctrl_stall_watchdog.sv | 50 +++++
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline stall/flush scheduler
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        PIPE_ST_RUN = 1'b0,
        PIPE_ST_IRQ = 1'b1
    } pipe_state_e;

    localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h0000_0010;
    localparam logic [31:0] ZERO_WORD          = 32'h0000_0000;

    typedef struct packed {
        logic hold_pc;
        logic hold_if_id;
        logic hold_id_ex;
        logic hold_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
        logic flush_mem_wb;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_IDLE = '0;

    // True when some stage register is asked to both keep and clear its value.
    function automatic logic ctrl_conflict(input stage_ctrl_t c);
        return (c.hold_if_id & c.flush_if_id) |
               (c.hold_id_ex & c.flush_id_ex) |
               (c.hold_ex_mem & c.flush_ex_mem);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_stall_watchdog.sv
// ============================================================================
// Module   : pipe_ctrl_stall_watchdog
// Purpose  : Counts consecutive data-bus stall cycles, pulses once at the limit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_i,
    output logic timeout_o
);

    localparam int             W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0]   C_MAX = W'(TIMEOUT_CYC);
    localparam logic [W-1:0]   C_PRE = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] count_q, count_d;
    logic         timeout_q, timeout_d;

    always_comb begin
        count_d   = '0;
        timeout_d = 1'b0;
        if (stall_i) begin
            count_d   = (count_q == C_MAX) ? C_MAX : count_q + W'(1);
            // Fires only on the step into the limit, never while saturated.
            timeout_d = (count_q == C_PRE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Priority stall/flush scheduler, interrupt entry/exit and EPC capture
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR  = DEFAULT_IRQ_VECTOR,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    input  logic        div_busy_i,
    input  logic        if_ready_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mret_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        irq_i,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        hold_ex_mem_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        flush_ex_mem_o,
    output logic        flush_mem_wb_o,
    output logic        pc_set_o,
    output logic [31:0] pc_set_addr_o,
    output logic        irq_ack_o,
    output logic [31:0] epc_o,
    output logic        bus_timeout_o
);

    pipe_state_e state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic        rst_done_q;

    stage_ctrl_t ctrl;
    logic        pc_set;
    logic [31:0] pc_addr;
    logic        irq_ack;
    logic        mem_stall;
    logic        irq_entry;
    logic        wd_stall;

    // Nothing is scheduled until one clean edge has passed after reset release.
    assign mem_stall = rst_done_q & mem_req_i & ~mem_ready_i;
    assign wd_stall  = mem_stall;
    assign irq_entry = (state_q == PIPE_ST_RUN) & irq_i & ex_valid_i & ~jump_i;

    always_comb begin
        ctrl    = CTRL_IDLE;
        pc_set  = 1'b0;
        pc_addr = ZERO_WORD;
        irq_ack = 1'b0;
        state_d = state_q;
        epc_d   = epc_q;
        if (rst_done_q) begin
            if (mem_stall) begin
                ctrl.hold_pc      = 1'b1;
                ctrl.hold_if_id   = 1'b1;
                ctrl.hold_id_ex   = 1'b1;
                ctrl.hold_ex_mem  = 1'b1;
                ctrl.flush_mem_wb = 1'b1;
            end else if (div_busy_i) begin
                ctrl.hold_pc      = 1'b1;
                ctrl.hold_if_id   = 1'b1;
                ctrl.hold_id_ex   = 1'b1;
                ctrl.flush_ex_mem = 1'b1;
            end else if (irq_entry) begin
                // EX instruction is killed here and re-executed from EPC on mret.
                ctrl.flush_if_id  = 1'b1;
                ctrl.flush_id_ex  = 1'b1;
                ctrl.flush_ex_mem = 1'b1;
                pc_set            = 1'b1;
                pc_addr           = IRQ_VECTOR;
                irq_ack           = 1'b1;
                epc_d             = ex_pc_i;
                state_d           = PIPE_ST_IRQ;
            end else if (jump_i) begin
                ctrl.flush_if_id  = 1'b1;
                ctrl.flush_id_ex  = 1'b1;
                pc_set            = 1'b1;
                pc_addr           = jump_addr_i;
                if ((state_q == PIPE_ST_IRQ) && mret_i) begin
                    state_d = PIPE_ST_RUN;
                end
            end else if (load_use_i) begin
                ctrl.hold_pc      = 1'b1;
                ctrl.hold_if_id   = 1'b1;
                ctrl.flush_id_ex  = 1'b1;
            end else if (!if_ready_i) begin
                ctrl.hold_pc      = 1'b1;
                ctrl.flush_if_id  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PIPE_ST_RUN;
            epc_q      <= ZERO_WORD;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            rst_done_q <= 1'b1;
        end
    end

    pipe_ctrl_stall_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stall_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_i   (wd_stall),
        .timeout_o (bus_timeout_o)
    );

    assign hold_pc_o      = ctrl.hold_pc;
    assign hold_if_id_o   = ctrl.hold_if_id;
    assign hold_id_ex_o   = ctrl.hold_id_ex;
    assign hold_ex_mem_o  = ctrl.hold_ex_mem;
    assign flush_if_id_o  = ctrl.flush_if_id;
    assign flush_id_ex_o  = ctrl.flush_id_ex;
    assign flush_ex_mem_o = ctrl.flush_ex_mem;
    assign flush_mem_wb_o = ctrl.flush_mem_wb;
    assign pc_set_o       = pc_set;
    assign pc_set_addr_o  = pc_addr;
    assign irq_ack_o      = irq_ack;
    assign epc_o          = epc_q;

    always_comb begin
        assert (!ctrl_conflict(ctrl));
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Vector table, directed corner sequences and random run for pipe_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam logic [31:0] C_IRQ_VEC = 32'h0000_0010;
    localparam int          C_TMO     = 64;

    logic        clk, rst_n;
    logic        load_use_i, mem_req_i, mem_ready_i, div_busy_i, if_ready_i;
    logic        jump_i, mret_i, ex_valid_i, irq_i;
    logic [31:0] jump_addr_i, ex_pc_i;
    logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o;
    logic        flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o;
    logic        pc_set_o, irq_ack_o, bus_timeout_o;
    logic [31:0] pc_set_addr_o, epc_o;

    pipe_ctrl #(.IRQ_VECTOR(C_IRQ_VEC), .TIMEOUT_CYC(C_TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_i(load_use_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .div_busy_i(div_busy_i), .if_ready_i(if_ready_i), .jump_i(jump_i),
        .jump_addr_i(jump_addr_i), .mret_i(mret_i), .ex_valid_i(ex_valid_i),
        .ex_pc_i(ex_pc_i), .irq_i(irq_i),
        .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
        .hold_ex_mem_o(hold_ex_mem_o), .flush_if_id_o(flush_if_id_o),
        .flush_id_ex_o(flush_id_ex_o), .flush_ex_mem_o(flush_ex_mem_o),
        .flush_mem_wb_o(flush_mem_wb_o), .pc_set_o(pc_set_o), .pc_set_addr_o(pc_set_addr_o),
        .irq_ack_o(irq_ack_o), .epc_o(epc_o), .bus_timeout_o(bus_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        load_use, mem_req, mem_ready, div_busy, if_ready, jump;
        logic [31:0] jump_addr;
        logic        mret, ex_valid;
        logic [31:0] ex_pc;
        logic        irq;
    } in_t;

    // hold = {pc,if_id,id_ex,ex_mem}, flush = {if_id,id_ex,ex_mem,mem_wb}
    typedef struct packed {
        logic [3:0]  hold;
        logic [3:0]  flush;
        logic        pc_set;
        logic [31:0] addr;
        logic        ack;
        logic [31:0] epc;
        logic        timeout;
    } obs_t;

    typedef struct {
        in_t         in;
        logic [3:0]  hold;
        logic [3:0]  flush;
        logic        pc_set;
        logic [31:0] addr;
    } vec_t;

    int   n_checks, n_errors;
    obs_t last_obs;

    // Reference model state: plain spec-level quantities.
    bit          m_active, m_in_irq, m_timeout;
    logic [31:0] m_epc;
    int          m_run;

    function automatic in_t mk(input logic [5:0] f, input logic [31:0] ja);
        in_t v = '0;
        {v.load_use, v.mem_req, v.mem_ready, v.div_busy, v.if_ready, v.jump} = f;
        v.jump_addr = ja;
        return v;
    endfunction

    function automatic in_t idle_in();
        return mk(6'b000010, 32'h0);
    endfunction

    // Which numbered priority rule governs this cycle.
    function automatic int rule_of(input in_t v);
        if (v.mem_req && !v.mem_ready)                       return 1;
        if (v.div_busy)                                      return 2;
        if (!m_in_irq && v.irq && v.ex_valid && !v.jump)     return 3;
        if (v.jump)                                          return 4;
        if (v.load_use)                                      return 5;
        if (!v.if_ready)                                     return 6;
        return 7;
    endfunction

    function automatic obs_t model_out(input in_t v);
        obs_t o = '0;
        int   r;
        if (!m_active) return o;
        r = rule_of(v);
        case (r)
            1: begin o.hold = 4'b1111; o.flush = 4'b0001; end
            2: begin o.hold = 4'b1110; o.flush = 4'b0010; end
            3: begin o.flush = 4'b1110; o.pc_set = 1'b1; o.addr = C_IRQ_VEC; o.ack = 1'b1; end
            4: begin o.flush = 4'b1100; o.pc_set = 1'b1; o.addr = v.jump_addr; end
            5: begin o.hold = 4'b1100; o.flush = 4'b0100; end
            6: begin o.hold = 4'b1000; o.flush = 4'b1000; end
            default: ;
        endcase
        o.epc     = m_epc;
        o.timeout = m_timeout;
        return o;
    endfunction

    function automatic void model_update(input in_t v);
        int r;
        if (!m_active) begin
            m_active = 1'b1;
            return;
        end
        r = rule_of(v);
        m_run     = (v.mem_req && !v.mem_ready) ? m_run + 1 : 0;
        m_timeout = (m_run == C_TMO);
        if (r == 3) begin
            m_in_irq = 1'b1;
            m_epc    = v.ex_pc;
        end else if (r == 4 && m_in_irq && v.mret) begin
            m_in_irq = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_active = 1'b0; m_in_irq = 1'b0; m_timeout = 1'b0; m_epc = '0; m_run = 0;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.hold    = {hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o};
        o.flush   = {flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o};
        o.pc_set  = pc_set_o;
        o.addr    = pc_set_addr_o;
        o.ack     = irq_ack_o;
        o.epc     = epc_o;
        o.timeout = bus_timeout_o;
        return o;
    endfunction

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got hold=%b flush=%b set=%b addr=%h ack=%b epc=%h to=%b, expected hold=%b flush=%b set=%b addr=%h ack=%b epc=%h to=%b",
                     name, got.hold, got.flush, got.pc_set, got.addr, got.ack, got.epc, got.timeout,
                     exp.hold, exp.flush, exp.pc_set, exp.addr, exp.ack, exp.epc, exp.timeout);
        end
    endtask

    task automatic drive(input in_t v);
        load_use_i = v.load_use; mem_req_i = v.mem_req; mem_ready_i = v.mem_ready;
        div_busy_i = v.div_busy; if_ready_i = v.if_ready; jump_i = v.jump;
        jump_addr_i = v.jump_addr; mret_i = v.mret; ex_valid_i = v.ex_valid;
        ex_pc_i = v.ex_pc; irq_i = v.irq;
    endtask

    // One cycle: drive on negedge, compare against the model, advance the model at posedge.
    task automatic step(input in_t v);
        @(negedge clk);
        drive(v);
        #1;
        last_obs = sample();
        check_obs("model", last_obs, model_out(v));
        @(posedge clk);
        model_update(v);
    endtask

    vec_t tbl[11];
    int   stall_left;
    int   pulses;

    initial begin
        in_t v, v_mret;
        n_checks = 0; n_errors = 0; stall_left = 0;
        model_reset();

        tbl[0]  = '{mk(6'b000010, 32'h0),   4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[1]  = '{mk(6'b100011, 32'h100), 4'b0000, 4'b1100, 1'b1, 32'h100};
        tbl[2]  = '{mk(6'b100010, 32'h0),   4'b1100, 4'b0100, 1'b0, 32'h0};
        tbl[3]  = '{mk(6'b000000, 32'h0),   4'b1000, 4'b1000, 1'b0, 32'h0};
        tbl[4]  = '{mk(6'b010011, 32'h200), 4'b1111, 4'b0001, 1'b0, 32'h0};
        tbl[5]  = '{mk(6'b011011, 32'h200), 4'b0000, 4'b1100, 1'b1, 32'h200};
        tbl[6]  = '{mk(6'b000111, 32'h300), 4'b1110, 4'b0010, 1'b0, 32'h0};
        tbl[7]  = '{mk(6'b010110, 32'h0),   4'b1111, 4'b0001, 1'b0, 32'h0};
        tbl[8]  = '{mk(6'b100000, 32'h0),   4'b1100, 4'b0100, 1'b0, 32'h0};
        tbl[9]  = '{mk(6'b000001, 32'h400), 4'b0000, 4'b1100, 1'b1, 32'h400};
        tbl[10] = '{mk(6'b100100, 32'h0),   4'b1110, 4'b0010, 1'b0, 32'h0};

        // Reset with an active jump request: everything must stay quiet.
        rst_n = 1'b0;
        drive(mk(6'b000011, 32'h100));
        repeat (2) @(posedge clk);
        #1 check_obs("in_reset", sample(), '0);
        #1 rst_n = 1'b1;
        step(mk(6'b000011, 32'h100));
        check_val("rst_done_gate", 64'(last_obs.pc_set), 64'h0);
        step(idle_in());
        check_obs("idle_after_reset", last_obs, '0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].in);
            check_val($sformatf("vec%0d", i), {23'h0, last_obs.hold, last_obs.flush, last_obs.pc_set, last_obs.addr},
                      {23'h0, tbl[i].hold, tbl[i].flush, tbl[i].pc_set, tbl[i].addr});
        end

        // Interrupt entry, no re-entry while active, mret return, re-acceptance.
        v = idle_in(); v.irq = 1'b1; v.ex_valid = 1'b1; v.ex_pc = 32'h40;
        step(v);
        check_val("irq_entry", {last_obs.ack, last_obs.pc_set, last_obs.addr, last_obs.flush, last_obs.hold},
                  {1'b1, 1'b1, 32'h10, 4'b1110, 4'b0000});
        for (int i = 0; i < 4; i++) begin
            step(v);
            check_val("irq_no_reack", {last_obs.ack, last_obs.epc}, {1'b0, 32'h40});
        end
        v_mret = v; v_mret.jump = 1'b1; v_mret.mret = 1'b1; v_mret.jump_addr = last_obs.epc;
        step(v_mret);
        check_val("mret_redirect", {last_obs.pc_set, last_obs.addr, last_obs.ack}, {1'b1, 32'h40, 1'b0});
        step(v);
        check_val("irq_reaccept", 64'(last_obs.ack), 64'h1);
        step(v_mret);

        // Entry deferred by the divider, then by a bubble in EX.
        v = idle_in(); v.irq = 1'b1; v.ex_valid = 1'b1; v.ex_pc = 32'h80; v.div_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(v);
            check_val("irq_div_defer", {last_obs.ack, last_obs.hold}, {1'b0, 4'b1110});
        end
        v.div_busy = 1'b0;
        step(v);
        check_val("irq_after_div", 64'(last_obs.ack), 64'h1);
        v_mret = v; v_mret.jump = 1'b1; v_mret.mret = 1'b1; v_mret.jump_addr = 32'h80;
        step(v_mret);
        v.ex_valid = 1'b0; v.ex_pc = 32'h90;
        for (int i = 0; i < 3; i++) begin
            step(v);
            check_val("irq_bubble_defer", 64'(last_obs.ack), 64'h0);
        end
        v.ex_valid = 1'b1;
        step(v);
        step(idle_in());
        check_val("irq_valid_epc", {last_obs.epc}, 32'h90);
        v_mret = idle_in(); v_mret.jump = 1'b1; v_mret.mret = 1'b1; v_mret.jump_addr = 32'h90;
        step(v_mret);

        // Long bus stall with a pending jump: watchdog pulses once, jump follows the stall.
        v = mk(6'b010011, 32'h300);
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            step(v);
            pulses += int'(last_obs.timeout);
            check_val("stall_ctrl", {last_obs.hold, last_obs.flush, last_obs.pc_set, last_obs.timeout},
                      {4'b1111, 4'b0001, 1'b0, (i == C_TMO)});
        end
        check_val("timeout_pulses", 64'(pulses), 64'h1);
        v.mem_ready = 1'b1;
        step(v);
        check_val("jump_after_stall", {last_obs.pc_set, last_obs.addr, last_obs.timeout}, {1'b1, 32'h300, 1'b0});

        // Asynchronous reset in the middle of an interrupt and a stall.
        v = idle_in(); v.irq = 1'b1; v.ex_valid = 1'b1; v.ex_pc = 32'h44;
        step(v);
        v = mk(6'b010011, 32'h500);
        for (int i = 0; i < 3; i++) step(v);
        #2 rst_n = 1'b0;
        #1 check_obs("async_reset", sample(), '0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        v = idle_in(); v.irq = 1'b1; v.ex_valid = 1'b1; v.ex_pc = 32'h48;
        step(v);
        check_val("post_reset_gate", 64'(last_obs.ack), 64'h0);
        step(v);
        check_val("post_reset_irq", {last_obs.ack, last_obs.addr}, {1'b1, 32'h10});

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            v = idle_in();
            if (stall_left > 0) begin
                v.mem_req = 1'b1; v.mem_ready = 1'b0; stall_left--;
            end else begin
                if ($urandom_range(0, 299) == 0) stall_left = int'($urandom_range(66, 72));
                v.mem_req   = ($urandom_range(0, 9) < 3);
                v.mem_ready = ($urandom_range(0, 1) == 1);
            end
            v.load_use  = ($urandom_range(0, 9) < 2);
            v.div_busy  = ($urandom_range(0, 9) < 2);
            v.if_ready  = ($urandom_range(0, 9) < 8);
            v.jump      = ($urandom_range(0, 9) < 3);
            v.mret      = v.jump && ($urandom_range(0, 1) == 1);
            v.jump_addr = $urandom;
            v.irq       = ($urandom_range(0, 9) < 4);
            v.ex_valid  = ($urandom_range(0, 9) < 7);
            v.ex_pc     = $urandom;
            step(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
